// File: rtl/controle_votacao.sv
// ============================================================================
// Module   : controle_votacao
// Purpose  : Sequences the day-vote phase. Alive players vote in index order
//            (target on alvo, confirmed with passa); one vote counter per
//            player is kept. After the last voter the counters are scanned
//            one per cycle and the player to eliminate is reported, or
//            "no elimination" on a tie or when no votes were cast.
// Ports    : clock, reset (async, active-high)
//            inicia          - start pulse, honoured only when idle
//            passa           - confirm pulse for the current voter
//            alvo            - target chosen by the current voter
//            vivos           - alive mask, stable from inicia to fim
//            jogador         - current voter / scan index
//            aguardando_voto - high while waiting for a vote
//            eliminado/valido- registered result, held until next phase
//            fim             - one-cycle end-of-phase pulse
//            db_estado       - state code (4'hF if illegal)
// Options  : DESEMPATE_MENOR_INDICE_EN - ties resolved to lowest index
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module controle_votacao #(
  parameter int N_JOGADORES = 8,
  parameter int W_J         = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inicia,
  input  logic                   passa,
  input  logic [W_J-1:0]         alvo,
  input  logic [N_JOGADORES-1:0] vivos,
  output logic [W_J-1:0]         jogador,
  output logic                   aguardando_voto,
  output logic [W_J-1:0]         eliminado,
  output logic                   valido,
  output logic                   fim,
  output logic [3:0]             db_estado
);

  localparam logic [3:0] c_OCIOSO        = 4'd0;
  localparam logic [3:0] c_ZERA          = 4'd1;
  localparam logic [3:0] c_BUSCA_VOTANTE = 4'd2;
  localparam logic [3:0] c_ESPERA_VOTO   = 4'd3;
  localparam logic [3:0] c_REGISTRA      = 4'd4;
  localparam logic [3:0] c_APURA         = 4'd5;
  localparam logic [3:0] c_RESULTADO     = 4'd6;

  localparam logic [W_J-1:0] c_ULTIMO = W_J'(N_JOGADORES - 1);

  logic [3:0]     r_estado;
  logic [3:0]     w_proximo;
  logic [W_J-1:0] r_jogador;
  logic [W_J-1:0] r_alvo;
  logic [W_J-1:0] r_eliminado;
  logic           r_valido;
  logic [W_J:0]   r_cont [N_JOGADORES];
  logic [W_J:0]   r_max;
  logic [W_J-1:0] r_cand;
  logic           r_empate;

  // Alive mask padded to the full index range: slots >= N_JOGADORES read as
  // dead, which also rejects out-of-range targets without a separate compare.
  logic [2**W_J-1:0] w_vivos_ext;
  logic              w_voto_valido;
  logic              w_ultimo;
  logic [W_J:0]      w_cont_atual;

  always_comb begin
    w_vivos_ext                = '0;
    w_vivos_ext[N_JOGADORES-1:0] = vivos;
  end

  assign w_voto_valido = w_vivos_ext[alvo] && (alvo != r_jogador);
  assign w_ultimo      = (r_jogador == c_ULTIMO);
  assign w_cont_atual  = r_cont[r_jogador];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= c_OCIOSO;
    else       r_estado <= w_proximo;
  end

  // Next-state logic
  always_comb begin
    w_proximo = c_OCIOSO;
    case (r_estado)
      c_OCIOSO:        w_proximo = inicia ? c_ZERA : c_OCIOSO;
      c_ZERA:          w_proximo = c_BUSCA_VOTANTE;
      c_BUSCA_VOTANTE: begin
        if (w_vivos_ext[r_jogador]) w_proximo = c_ESPERA_VOTO;
        else if (w_ultimo)          w_proximo = c_APURA;
        else                        w_proximo = c_BUSCA_VOTANTE;
      end
      c_ESPERA_VOTO:   w_proximo = (passa && w_voto_valido) ? c_REGISTRA : c_ESPERA_VOTO;
      c_REGISTRA:      w_proximo = w_ultimo ? c_APURA : c_BUSCA_VOTANTE;
      c_APURA:         w_proximo = w_ultimo ? c_RESULTADO : c_APURA;
      c_RESULTADO:     w_proximo = c_OCIOSO;
      default:         w_proximo = c_OCIOSO;
    endcase
  end

  // Datapath: voter index, counters, scan registers and result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_jogador   <= '0;
      r_alvo      <= '0;
      r_eliminado <= '0;
      r_valido    <= 1'b0;
      r_max       <= '0;
      r_cand      <= '0;
      r_empate    <= 1'b0;
      for (int i = 0; i < N_JOGADORES; i++) r_cont[i] <= '0;
    end else begin
      case (r_estado)
        c_ZERA: begin
          r_jogador   <= '0;
          r_eliminado <= '0;
          r_valido    <= 1'b0;
          r_max       <= '0;
          r_cand      <= '0;
          r_empate    <= 1'b0;
          for (int i = 0; i < N_JOGADORES; i++) r_cont[i] <= '0;
        end
        c_BUSCA_VOTANTE: begin
          if (!w_vivos_ext[r_jogador])
            r_jogador <= w_ultimo ? '0 : r_jogador + 1'b1;
        end
        c_ESPERA_VOTO: begin
          if (passa && w_voto_valido) r_alvo <= alvo;
        end
        c_REGISTRA: begin
          // W_J+1 bits hold up to 2**W_J votes, so no saturation is needed
          r_cont[r_alvo] <= r_cont[r_alvo] + 1'b1;
          r_jogador      <= w_ultimo ? '0 : r_jogador + 1'b1;
        end
        c_APURA: begin
          if (w_cont_atual > r_max) begin
            r_max    <= w_cont_atual;
            r_cand   <= r_jogador;
            r_empate <= 1'b0;
          end else if ((w_cont_atual == r_max) && (r_max != '0)) begin
`ifdef DESEMPATE_MENOR_INDICE_EN
            // Keep the earlier (lower-index) candidate on equal count
            r_empate <= 1'b0;
`else
            r_empate <= 1'b1;
`endif
          end
          r_jogador <= w_ultimo ? '0 : r_jogador + 1'b1;
        end
        c_RESULTADO: begin
          r_eliminado <= r_cand;
          r_valido    <= (r_max != '0) && !r_empate;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    aguardando_voto = (r_estado == c_ESPERA_VOTO);
    fim             = (r_estado == c_RESULTADO);
    case (r_estado)
      c_OCIOSO, c_ZERA, c_BUSCA_VOTANTE, c_ESPERA_VOTO,
      c_REGISTRA, c_APURA, c_RESULTADO: db_estado = r_estado;
      default:                          db_estado = 4'hF;
    endcase
  end

  assign jogador   = r_jogador;
  assign eliminado = r_eliminado;
  assign valido    = r_valido;

endmodule

`default_nettype wire

// File: tb/tb_controle_votacao.sv
// ============================================================================
// Module   : tb_controle_votacao
// Purpose  : Self-checking bench for controle_votacao (N_JOGADORES=8, W_J=3).
//            Table of complete vote phases with expected results, plus
//            directed sequences for reset mid-phase, invalid votes and the
//            no-alive-player timing. Honours DESEMPATE_MENOR_INDICE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controle_votacao;

  localparam int N = 8;
  localparam int W = 3;
`ifdef DESEMPATE_MENOR_INDICE_EN
  localparam bit c_DESEMP = 1'b1;
`else
  localparam bit c_DESEMP = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         inicia = 1'b0;
  logic         passa = 1'b0;
  logic [W-1:0] alvo = '0;
  logic [N-1:0] vivos = '0;
  logic [W-1:0] jogador;
  logic         aguardando_voto;
  logic [W-1:0] eliminado;
  logic         valido;
  logic         fim;
  logic [3:0]   db_estado;

  int n_cmp = 0;
  int n_err = 0;

  controle_votacao #(.N_JOGADORES(N), .W_J(W)) dut (
    .clock           (clock),
    .reset           (reset),
    .inicia          (inicia),
    .passa           (passa),
    .alvo            (alvo),
    .vivos           (vivos),
    .jogador         (jogador),
    .aguardando_voto (aguardando_voto),
    .eliminado       (eliminado),
    .valido          (valido),
    .fim             (fim),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  vivos;
    logic [23:0] votos;     // vote of player i in bits [3i+2:3i]
    logic [2:0]  exp_elim;
    logic        exp_val;
  } vetor_t;

  vetor_t tab [7];

  task automatic chk(input string nome, input int atual, input int esperado);
    n_cmp++;
    if (atual != esperado) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
    end
  endtask

  function automatic logic [23:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  // Wait (bounded) for aguardando_voto or fim, sampling on negedge
  task automatic espera(input bit quer_fim, input string nome);
    int n = 0;
    while (!(quer_fim ? fim : aguardando_voto) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk({"timeout_", nome}, 0, 1);
  endtask

  // Run one full phase; checks visited voters, fim width, result
  task automatic run_fase(input logic [7:0] v, input logic [23:0] votos,
                          input logic [2:0] e_elim, input logic e_val,
                          input string nome);
    logic [7:0]  visitados = '0;
    logic [23:0] vt = votos;
    bit          feito = 0;
    int          ciclos = 0;
    @(negedge clock);
    vivos  = v;
    inicia = 1'b1;
    @(negedge clock);
    inicia = 1'b0;
    while (!feito && ciclos < 300) begin
      if (aguardando_voto) begin
        visitados[jogador] = 1'b1;
        alvo  = vt[3*int'(jogador) +: 3];
        passa = 1'b1;
        @(negedge clock);
        passa = 1'b0;
      end else if (fim) begin
        feito = 1;
        chk({nome, "_estado_fim"}, int'(db_estado), 6);
        @(negedge clock);
        chk({nome, "_fim_1ciclo"}, int'(fim), 0);
      end else begin
        @(negedge clock);
      end
      ciclos++;
    end
    if (!feito) chk({nome, "_timeout"}, 0, 1);
    chk({nome, "_visitados"}, int'(visitados), int'(v));
    chk({nome, "_eliminado"}, int'(eliminado), int'(e_elim));
    chk({nome, "_valido"}, int'(valido), int'(e_val));
    chk({nome, "_ocioso"}, int'(db_estado), 0);
  endtask

  initial begin
    tab[0] = '{8'hFF, pk(3,3,3,0,3,1,2,1), 3'd3, 1'b1};
    tab[1] = '{8'hA5, pk(2,0,5,0,0,2,0,2), 3'd2, 1'b1};
    tab[2] = '{8'h0F, pk(1,0,3,2,0,0,0,0), 3'd0, c_DESEMP};
    tab[3] = '{8'h00, pk(0,0,0,0,0,0,0,0), 3'd0, 1'b0};
    tab[4] = '{8'hFF, pk(6,4,6,4,5,7,5,1), 3'd4, c_DESEMP};
    tab[5] = '{8'h46, pk(0,6,6,0,0,0,1,0), 3'd6, 1'b1};
    tab[6] = '{8'hFF, pk(7,0,7,5,7,3,2,6), 3'd7, 1'b1};

    // Reset state
    #1 reset = 1'b1;
    #1;
    chk("rst_estado", int'(db_estado), 0);
    chk("rst_fim", int'(fim), 0);
    chk("rst_valido", int'(valido), 0);
    chk("rst_aguardando", int'(aguardando_voto), 0);
    chk("rst_jogador", int'(jogador), 0);
    chk("rst_eliminado", int'(eliminado), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Table of complete phases
    for (int i = 0; i < 7; i++)
      run_fase(tab[i].vivos, tab[i].votos, tab[i].exp_elim, tab[i].exp_val,
               $sformatf("vet%0d", i));

    // Reset asserted while waiting for player 2's vote
    @(negedge clock);
    vivos  = 8'hFF;
    inicia = 1'b1;
    @(negedge clock);
    inicia = 1'b0;
    for (int k = 0; k < 2; k++) begin
      espera(0, "rstmeio");
      alvo  = 3'd3;
      passa = 1'b1;
      @(negedge clock);
      passa = 1'b0;
    end
    espera(0, "rstmeio");
    chk("rstmeio_antes", int'(db_estado), 3);
    #2 reset = 1'b1;
    #1;
    chk("rstmeio_estado", int'(db_estado), 0);
    chk("rstmeio_fim", int'(fim), 0);
    chk("rstmeio_valido", int'(valido), 0);
    chk("rstmeio_jogador", int'(jogador), 0);
    @(negedge clock);
    reset = 1'b0;
    // Stale counter[3]=2 would make player 3 the result here
    run_fase(8'h03, pk(1,0,0,0,0,0,0,0), 3'd0, c_DESEMP, "posrst");

    // Invalid votes: own index, dead player, inicia while waiting, then valid
    @(negedge clock);
    vivos  = 8'h07;
    inicia = 1'b1;
    @(negedge clock);
    inicia = 1'b0;
    espera(0, "inval0");
    chk("inval_jogador0", int'(jogador), 0);
    alvo = 3'd0; passa = 1'b1; @(negedge clock); passa = 1'b0;
    chk("inval_proprio", int'(db_estado), 3);
    alvo = 3'd5; passa = 1'b1; @(negedge clock); passa = 1'b0;
    chk("inval_morto", int'(db_estado), 3);
    inicia = 1'b1; @(negedge clock); inicia = 1'b0;
    chk("inval_inicia", int'(db_estado), 3);
    alvo = 3'd1; passa = 1'b1; @(negedge clock); passa = 1'b0;
    chk("inval_registra", int'(db_estado), 4);
    espera(0, "inval1");
    chk("inval_jogador1", int'(jogador), 1);
    alvo = 3'd0; passa = 1'b1; @(negedge clock); passa = 1'b0;
    espera(0, "inval2");
    chk("inval_jogador2", int'(jogador), 2);
    alvo = 3'd1; passa = 1'b1; @(negedge clock); passa = 1'b0;
    espera(1, "inval_fim");
    @(negedge clock);
    chk("inval_eliminado", int'(eliminado), 1);
    chk("inval_valido", int'(valido), 1);

    // No alive players: exact state timeline, inicia+passa together in
    // OCIOSO, and an ignored inicia during APURA
    @(negedge clock);
    vivos  = 8'h00;
    inicia = 1'b1;
    passa  = 1'b1;
    @(negedge clock);
    inicia = 1'b0;
    passa  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      int esp;
      if (k == 0)       esp = 1;
      else if (k <= 8)  esp = 2;
      else if (k <= 16) esp = 5;
      else if (k == 17) esp = 6;
      else              esp = 0;
      chk($sformatf("vazio_estado_%0d", k), int'(db_estado), esp);
      if (k == 17) chk("vazio_fim", int'(fim), 1);
      if (k == 18) chk("vazio_fim_baixo", int'(fim), 0);
      inicia = (k == 11);
      @(negedge clock);
      inicia = 1'b0;
    end
    chk("vazio_valido", int'(valido), 0);
    chk("vazio_eliminado", int'(eliminado), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/controle_votacao.md
Name: controle_votacao

Overview:
- Sequences the day-vote phase of the game after the night phase ends.
- Walks the alive players in index order; each one selects a target and confirms with `passa`. The block keeps one vote counter per player.
- After the last voter it scans the counters and reports the player to eliminate, or "no elimination" on a tie or when no votes were cast.
- Started by the main game controller, which waits for `fim`.

Parameters:
- N_JOGADORES, 8, number of player slots (2..16).
- W_J, 3, width of a player index; N_JOGADORES <= 2**W_J.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; returns the block to OCIOSO.
- inicia  in  1  one-cycle start pulse from the main controller; ignored outside OCIOSO.
- passa  in  1  debounced one-cycle confirm pulse from the players' button.
- alvo  in  W_J  target selected by the current voter.
- vivos  in  N_JOGADORES  alive mask; bit i = player i alive; must be held stable from `inicia` to `fim`.
- jogador  out  W_J  index of the current voter / scan index.
- aguardando_voto  out  1  high only in ESPERA_VOTO (drives the "vote now" display).
- eliminado  out  W_J  index of the player to eliminate; registered.
- valido  out  1  eliminado is meaningful; registered.
- fim  out  1  one-cycle pulse, in RESULTADO.
- db_estado  out  4  current state code; 4'hF for an illegal state.

Behaviour:
- Moore FSM; state codes: OCIOSO=0, ZERA=1, BUSCA_VOTANTE=2, ESPERA_VOTO=3, REGISTRA=4, APURA=5, RESULTADO=6.
- On reset:
  - state = OCIOSO; jogador, eliminado, valido, fim and aguardando_voto = 0.
  - All vote counters, max and tie flag = 0.
- OCIOSO: `inicia` -> ZERA.
- ZERA (1 cycle):
  - Clear all counters, max and tie flag; jogador = 0; valido = 0; eliminado = 0.
  - -> BUSCA_VOTANTE.
- BUSCA_VOTANTE: skips dead voters, one index per cycle.
  - vivos[jogador] = 1 -> ESPERA_VOTO.
  - Otherwise, if jogador == N_JOGADORES-1 -> APURA with jogador = 0.
  - Otherwise jogador + 1 and stay.
- ESPERA_VOTO: waits for `passa`.
  - A vote is valid only if alvo < N_JOGADORES, vivos[alvo] = 1 and alvo != jogador.
  - `passa` with a valid alvo -> REGISTRA, with alvo captured on that edge.
  - `passa` with an invalid alvo is ignored: stay, nothing recorded.
- REGISTRA (1 cycle):
  - Counter[captured alvo] + 1. Counters are W_J+1 bits, so they cannot overflow.
  - If jogador == N_JOGADORES-1 -> APURA with jogador = 0.
  - Otherwise jogador + 1 -> BUSCA_VOTANTE.
- APURA: scans one counter per cycle, idx = jogador from 0 to N_JOGADORES-1.
  - count > max: max = count, candidate = idx, tie = 0.
  - count == max and max != 0: tie = 1.
  - After idx N_JOGADORES-1 -> RESULTADO.
  - The scan takes exactly N_JOGADORES cycles.
- RESULTADO (1 cycle):
  - fim = 1; eliminado = candidate.
  - valido = (max != 0) and not tie.
  - -> OCIOSO.
  - eliminado and valido hold until the next ZERA.
- Simultaneous `inicia` and `passa` in OCIOSO: only `inicia` acts.
- `inicia` in any other state: ignored; the phase is not restarted.
- Reset mid-phase: immediate return to OCIOSO; counters are cleared; no `fim` is issued.
- Illegal state: db_estado = 4'hF, next state = OCIOSO.

Optional Feature:
- Macro DESEMPATE_MENOR_INDICE_EN.
- Defined: on a tie the lowest-index player among those tied at max is eliminated with valido = 1. The candidate is not updated on equal count. valido = 0 still applies when no votes were cast.
- Undefined: a tie gives valido = 0, as specified above.

Test Plan:
- Reset asserted mid-ESPERA_VOTO -> db_estado = 0, fim and valido = 0; after a new `inicia`, all counters read 0 (checked through the result).
- N=8, vivos=8'hFF; voters 0..7 vote 3,3,3,0,3,1,2,1 -> counter[3] = 4; RESULTADO gives eliminado = 3, valido = 1; fim high exactly 1 cycle; aguardando_voto high only while waiting.
- vivos=8'b1010_0101 -> jogador visits only 0, 2, 5, 7 in ESPERA_VOTO; votes 2,5,2,2 -> eliminado = 2, valido = 1.
- Invalid votes: alvo = own index, a dead player, then a valid one -> the first two `passa` are ignored (state stays 3); only the third is counted.
- vivos=8'h0F, votes 1,0,3,2 -> every alive player has count 1 (four-way tie):
  - macro undefined -> valido = 0.
  - macro defined -> eliminado = 0, valido = 1.
- vivos=8'h00 -> ZERA, 8 BUSCA_VOTANTE cycles, 8 APURA cycles, RESULTADO with valido = 0; `inicia` pulsed during APURA has no effect.
